// File: rtl/disparity_selector_pkg.sv
// disparity_selector_pkg
// Shared defaults, pipeline tag type and a constant-width helper for the
// SGM disparity selection stage.
// No ports (package).
package disparity_selector_pkg;

   localparam int DEF_DISPARITY_LEVELS = 64;
   localparam int DEF_ACC_COST_BITS    = 8;
   localparam int DEF_NUM_PATHS        = 4;

   // Side-band information that rides alongside each pixel in the pipeline.
   typedef struct packed {
      logic de;
      logic border;
   } tag_t;

   // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      for (r = 0; (1 << r) < value; r++) begin
      end
      return r;
   endfunction

endpackage

// File: rtl/disparity_selector_argmin.sv
// pipelined_argmin
// Fully pipelined argmin over INPUTS values (INPUTS a power of two).
// One registered compare level per log2(INPUTS); ties go to the lower index.
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset (clears all tree registers)
//   vals     - INPUTS packed values, index i at vals[i]
//   min_val  - smallest value, log2(INPUTS) cycles after vals
//   min_idx  - index of min_val
module pipelined_argmin
   import disparity_selector_pkg::*;
#(
   parameter  int WIDTH    = 8,
   parameter  int INPUTS   = 64,
   localparam int IDX_BITS = clog2(INPUTS)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [INPUTS-1:0][WIDTH-1:0]   vals,
   output logic [WIDTH-1:0]               min_val,
   output logic [IDX_BITS-1:0]            min_idx
);

   // Heap-ordered tree: node i has children 2i+1 and 2i+2. Nodes 0..INPUTS-2
   // are registers; children numbered INPUTS-1 and up are the raw inputs.
   // Left children always cover lower indices, so "right wins only if
   // strictly smaller" gives lower-index-wins on ties.
   logic [WIDTH-1:0]    node_val [INPUTS-1];
   logic [IDX_BITS-1:0] node_idx [INPUTS-1];

   for (genvar i = 0; i < INPUTS-1; i++) begin : g_node
      localparam int LC = 2*i + 1;
      localparam int RC = 2*i + 2;
      logic [WIDTH-1:0]    lv, rv;
      logic [IDX_BITS-1:0] li, ri;

      if (LC >= INPUTS-1) begin : g_leaf
         assign lv = vals[LC-(INPUTS-1)];
         assign rv = vals[RC-(INPUTS-1)];
         assign li = IDX_BITS'(LC-(INPUTS-1));
         assign ri = IDX_BITS'(RC-(INPUTS-1));
      end else begin : g_inner
         assign lv = node_val[LC];
         assign rv = node_val[RC];
         assign li = node_idx[LC];
         assign ri = node_idx[RC];
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            node_val[i] <= '0;
            node_idx[i] <= '0;
         end else if (rv < lv) begin
            node_val[i] <= rv;
            node_idx[i] <= ri;
         end else begin
            node_val[i] <= lv;
            node_idx[i] <= li;
         end
      end
   end

   assign min_val = node_val[0];
   assign min_idx = node_idx[0];

endmodule

// File: rtl/disparity_selector.sv
// disparity_selector
// Sums NUM_PATHS aggregated path costs per disparity, picks the winner-take-all
// disparity with a pipelined argmin, and flags pixels in the left border
// (column < DISPARITY_LEVELS-1) as invalid. Latency DISP_BITS+2, 1 pixel/clk.
// Ports:
//   in_clk, in_rst      - clock, synchronous active-high reset
//   in_de               - input pixel valid
//   in_path_beginning   - first pixel of a row (qualified by in_de)
//   in_L_arr            - path p, disparity d at word p*DISPARITY_LEVELS+d
//   out_de              - in_de delayed by LATENCY
//   out_disp            - selected disparity
//   out_min_cost        - aggregated cost of out_disp
//   out_disp_valid      - out_de and pixel not in the left border
module disparity_selector
   import disparity_selector_pkg::*;
#(
   parameter  int DISPARITY_LEVELS = DEF_DISPARITY_LEVELS,
   parameter  int ACC_COST_BITS    = DEF_ACC_COST_BITS,
   parameter  int NUM_PATHS        = DEF_NUM_PATHS,
   localparam int DISP_BITS        = clog2(DISPARITY_LEVELS),
   localparam int SUM_BITS         = ACC_COST_BITS + clog2(NUM_PATHS),
   localparam int LATENCY          = DISP_BITS + 2
) (
   input  logic                                                in_clk,
   input  logic                                                in_rst,
   input  logic                                                in_de,
   input  logic                                                in_path_beginning,
   input  logic [NUM_PATHS*DISPARITY_LEVELS*ACC_COST_BITS-1:0] in_L_arr,
   output logic                                                out_de,
   output logic [DISP_BITS-1:0]                                out_disp,
   output logic [SUM_BITS-1:0]                                 out_min_cost,
   output logic                                                out_disp_valid
);

   localparam logic [DISP_BITS:0] COL_SAT = (DISP_BITS+1)'(DISPARITY_LEVELS-1);

   logic [DISPARITY_LEVELS-1:0][SUM_BITS-1:0] sum, sum_q;
   logic [DISP_BITS-1:0]                      win_idx;
   logic [SUM_BITS-1:0]                       win_val;
   logic [DISP_BITS:0]                        col, col_next;
   logic                                      border_next;
   tag_t                                      tags [LATENCY];

   // Stage 0: per-disparity sum; each term is zero-extended so S cannot wrap.
   always_comb begin
      sum = '0;
      for (int d = 0; d < DISPARITY_LEVELS; d++) begin
         for (int p = 0; p < NUM_PATHS; p++) begin
            sum[d] = sum[d] + SUM_BITS'(in_L_arr[(p*DISPARITY_LEVELS+d)*ACC_COST_BITS +: ACC_COST_BITS]);
         end
      end
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) sum_q <= '0;
      else        sum_q <= sum;
   end

   pipelined_argmin #(
      .WIDTH  (SUM_BITS),
      .INPUTS (DISPARITY_LEVELS)
   ) u_argmin (
      .clk     (in_clk),
      .rst     (in_rst),
      .vals    (sum_q),
      .min_val (win_val),
      .min_idx (win_idx)
   );

   // Column counter; the border flag uses the post-update value so the first
   // pixel of a row is column 0.
   always_comb begin
      col_next = col;
      if (in_de) begin
         if (in_path_beginning)  col_next = '0;
         else if (col != COL_SAT) col_next = col + (DISP_BITS+1)'(1);
      end
      border_next = (col_next < COL_SAT);
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) col <= '0;
      else        col <= col_next;
   end

   // Tag shift pipeline: tags[0] aligns with sum_q, tags[LATENCY-1] with the
   // output register.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         for (int i = 0; i < LATENCY; i++) tags[i] <= '{de: 1'b0, border: 1'b1};
      end else begin
         tags[0] <= '{de: in_de, border: border_next};
         for (int i = 1; i < LATENCY; i++) tags[i] <= tags[i-1];
      end
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         out_disp     <= '0;
         out_min_cost <= '0;
      end else begin
         out_disp     <= win_idx;
         out_min_cost <= win_val;
      end
   end

   assign out_de         = tags[LATENCY-1].de;
   assign out_disp_valid = tags[LATENCY-1].de & ~tags[LATENCY-1].border;

endmodule

// File: tb/tb_disparity_selector.sv
module tb_disparity_selector;

   localparam int DL  = 64;
   localparam int ACB = 8;
   localparam int NP  = 4;
   localparam int DB  = 6;
   localparam int SB  = 10;
   localparam int LAT = 8;

   logic                   in_clk = 1'b0;
   logic                   in_rst, in_de, in_path_beginning;
   logic [NP*DL*ACB-1:0]   lvec;
   logic                   out_de, out_disp_valid;
   logic [DB-1:0]          out_disp;
   logic [SB-1:0]          out_min_cost;

   disparity_selector dut (
      .in_clk            (in_clk),
      .in_rst            (in_rst),
      .in_de             (in_de),
      .in_path_beginning (in_path_beginning),
      .in_L_arr          (lvec),
      .out_de            (out_de),
      .out_disp          (out_disp),
      .out_min_cost      (out_min_cost),
      .out_disp_valid    (out_disp_valid)
   );

   always #5 in_clk = ~in_clk;

   typedef struct {
      int            issue;
      logic [DB-1:0] disp;
      logic [SB-1:0] cost;
      logic          valid;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   col = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
      end
   endtask

   task automatic set_word(input int p, input int d, input int v);
      lvec[(p*DL+d)*ACB +: ACB] = ACB'(v);
   endtask

   task automatic set_all(input int v);
      for (int p = 0; p < NP; p++)
         for (int d = 0; d < DL; d++) set_word(p, d, v);
   endtask

   task automatic set_rand();
      for (int p = 0; p < NP; p++)
         for (int d = 0; d < DL; d++) set_word(p, d, int'($urandom_range(0, 255)));
   endtask

   // Reference: linear scan, first strictly smaller sum wins.
   task automatic ref_min(output int dd, output int cc);
      int s;
      dd = 0;
      cc = -1;
      for (int d = 0; d < DL; d++) begin
         s = 0;
         for (int p = 0; p < NP; p++) s += int'(lvec[(p*DL+d)*ACB +: ACB]);
         if (cc < 0 || s < cc) begin
            cc = s;
            dd = d;
         end
      end
   endtask

   // One clock: drive inputs, push expectation, then check outputs #1 after edge.
   task automatic step(input bit rst, input bit de, input bit pb,
                       input bit fixed = 1'b0, input int fd = 0, input int fc = 0);
      exp_t e;
      int   md, mc;
      bit   exp_de;
      in_rst = rst;
      in_de = de;
      in_path_beginning = pb;
      if (rst) begin
         sb.delete();
         col = 0;
      end else if (de) begin
         col = pb ? 0 : ((col < DL-1) ? col + 1 : col);
         ref_min(md, mc);
         e.issue = cyc;
         e.disp  = DB'(fixed ? fd : md);
         e.cost  = SB'(fixed ? fc : mc);
         e.valid = (col >= DL-1);
         sb.push_back(e);
      end
      @(posedge in_clk);
      #1;
      cyc++;
      exp_de = (sb.size() > 0) && (sb[0].issue + LAT == cyc);
      chk("out_de", out_de, exp_de);
      if (exp_de) begin
         e = sb.pop_front();
         chk("out_disp", out_disp, e.disp);
         chk("out_min_cost", out_min_cost, e.cost);
         chk("out_disp_valid", out_disp_valid, e.valid);
      end else begin
         chk("idle_disp_valid", out_disp_valid, 0);
      end
   endtask

   initial begin
      in_rst = 1'b1;
      in_de = 1'b0;
      in_path_beginning = 1'b0;
      lvec = '0;

      // Reset state.
      step(1, 0, 0);
      step(1, 1, 1);
      chk("rst_out_de", out_de, 0);
      chk("rst_out_disp", out_disp, 0);
      chk("rst_out_min_cost", out_min_cost, 0);
      chk("rst_out_disp_valid", out_disp_valid, 0);

      // Single minimum at d=17.
      set_all(100);
      for (int p = 0; p < NP; p++) set_word(p, 17, 3);
      step(0, 1, 1, 1, 17, 12);

      // Tie between d=5 and d=9: lower index wins.
      set_all(0);
      for (int d = 0; d < DL; d++) set_word(0, d, 40);
      set_word(0, 5, 7);
      set_word(0, 9, 7);
      step(0, 1, 0, 1, 5, 7);

      // Maximum inputs: no wrap, all tie so d=0.
      set_all(255);
      step(0, 1, 0, 1, 0, 1020);

      for (int i = 0; i < 10; i++) step(0, 0, 0);

      // Border masking over a 100-pixel row with bubbles.
      for (int i = 0; i < 100; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            set_rand();
            step(0, 0, 0);
         end
         set_rand();
         step(0, 1, (i == 0));
      end

      // Random streaming with gaps and occasional new rows (hits saturated + pb).
      for (int i = 0; i < 200; i++) begin
         set_rand();
         step(0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
      end

      // Reset mid-row: in-flight pixels dropped, counter restarts at 0.
      set_rand();
      step(0, 1, 1);
      for (int i = 0; i < 10; i++) begin
         set_rand();
         step(0, 1, 0);
      end
      step(1, 1, 1);
      for (int i = 0; i < 12; i++) begin
         set_rand();
         step(0, 1, 0);
      end

      for (int i = 0; i < 12; i++) step(0, 0, 0);
      chk("scoreboard_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
